// File: rtl/accel_pkg.sv
// Shared definitions for the CNN accelerator: layer codes, engine indices,
// DRAM region map and the layer sequencer state encoding.
package accel_pkg;

  typedef enum logic [1:0] {
    LT_CONV = 2'd0,
    LT_POOL = 2'd1,
    LT_END  = 2'd2,
    LT_RSVD = 2'd3
  } layer_type_e;

  localparam int unsigned NUM_ENG  = 2;
  localparam int unsigned ENG_CONV = 0;
  localparam int unsigned ENG_POOL = 1;

  localparam int unsigned PARAM_BASE = 0;
  localparam int unsigned OFMAP_BASE = 65536;
  localparam int unsigned IFMAP_BASE = 131072;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLaunch,
    StRun,
    StDone
  } sched_state_e;

endpackage

// File: rtl/dram_port_mux.sv
// Combinational owner of the single DRAM port: the scheduler's descriptor
// fetch by default, or the selected engine while it holds the grant.
module dram_port_mux
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                          sel,
  input  logic                          grant_valid,
  input  logic                          sched_en_rd,
  input  logic [ADDR_WIDTH-1:0]         sched_addr_rd,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out,
  input  logic [NUM_ENG-1:0]            eng_en_rd,
  input  logic [NUM_ENG-1:0]            eng_en_wr,
  output logic                          dram_en_rd,
  output logic                          dram_en_wr,
  output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
  output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
  output logic [DATA_WIDTH-1:0]         dram_data_out
);

  always_comb begin
    dram_en_rd    = sched_en_rd;
    dram_addr_rd  = sched_addr_rd;
    dram_en_wr    = 1'b0;
    dram_addr_wr  = '0;
    dram_data_out = '0;
    if (grant_valid) begin
      dram_en_rd    = eng_en_rd[sel];
      dram_en_wr    = eng_en_wr[sel];
      dram_addr_rd  = sel ? eng_addr_in[2*ADDR_WIDTH-1:ADDR_WIDTH] : eng_addr_in[ADDR_WIDTH-1:0];
      dram_addr_wr  = sel ? eng_addr_out[2*ADDR_WIDTH-1:ADDR_WIDTH] :
                            eng_addr_out[ADDR_WIDTH-1:0];
      dram_data_out = sel ? eng_data_out[2*DATA_WIDTH-1:DATA_WIDTH] :
                            eng_data_out[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/layer_sched.sv
// Layer sequencer: fetches one-word descriptors, launches the matching engine
// and waits for its done before moving on; also arbitrates the DRAM port.
module layer_sched
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned MAX_LAYERS = 16,
  parameter int unsigned PROG_BASE  = 0
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          dram_valid,
  input  logic [DATA_WIDTH-1:0]         dram_data_in,
  output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
  output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
  output logic [DATA_WIDTH-1:0]         dram_data_out,
  output logic                          dram_en_rd,
  output logic                          dram_en_wr,
  output logic [NUM_ENG-1:0]            eng_enable,
  input  logic [NUM_ENG-1:0]            eng_done,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out,
  input  logic [NUM_ENG-1:0]            eng_en_rd,
  input  logic [NUM_ENG-1:0]            eng_en_wr
);

  // One extra bit so reaching MAX_LAYERS is visible instead of wrapping.
  localparam int unsigned IDX_W = $clog2(MAX_LAYERS) + 1;

  sched_state_e             state_q, state_d;
  logic         [IDX_W-1:0] idx_q, idx_d;
  layer_type_e              ltype_q, ltype_d;
  logic                     err_q, err_d;

  logic                     sched_en_rd;
  logic [ADDR_WIDTH-1:0]    sched_addr_rd;

  // Only the type field of a descriptor matters here; engines parse the rest.
  logic unused_bits;
  assign unused_bits = ^{dram_data_in[DATA_WIDTH-1:2], ltype_q[1]};

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ltype_q <= LT_CONV;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ltype_q <= ltype_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ltype_d = ltype_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (dram_valid) begin
          ltype_d = layer_type_e'(dram_data_in[1:0]);
          unique case (layer_type_e'(dram_data_in[1:0]))
            LT_CONV, LT_POOL: state_d = StLaunch;
            LT_END:           state_d = StDone;
            default: begin
              err_d   = 1'b1;
              state_d = StDone;
            end
          endcase
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        if (eng_done[ltype_q[0]]) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_d == IDX_W'(MAX_LAYERS)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    err           = err_q;
    eng_enable    = '0;
    sched_en_rd   = (state_q == StFetch);
    sched_addr_rd = '0;
    if (state_q == StLaunch) begin
      eng_enable[ltype_q[0]] = 1'b1;
    end
    if (state_q == StFetch) begin
      sched_addr_rd = ADDR_WIDTH'(PROG_BASE) + ADDR_WIDTH'(idx_q);
    end
  end

  dram_port_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dram_port_mux (
    .sel           (ltype_q[0]),
    .grant_valid   (state_q == StRun),
    .sched_en_rd   (sched_en_rd),
    .sched_addr_rd (sched_addr_rd),
    .eng_addr_in   (eng_addr_in),
    .eng_addr_out  (eng_addr_out),
    .eng_data_out  (eng_data_out),
    .eng_en_rd     (eng_en_rd),
    .eng_en_wr     (eng_en_wr),
    .dram_en_rd    (dram_en_rd),
    .dram_en_wr    (dram_en_wr),
    .dram_addr_rd  (dram_addr_rd),
    .dram_addr_wr  (dram_addr_wr),
    .dram_data_out (dram_data_out)
  );

endmodule
